// File: rtl/decode_queue.sv
// Opcode pre-decode stage: splits each fetched opcode into fields, classifies it,
// and buffers the classification in a DEPTH-entry FIFO; branches resolve at dequeue.
module decode_queue #(
  parameter int unsigned DEPTH       = 2,
  parameter bit          ILLEGAL_NOP = 1'b0
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           flush,
  input  logic                           in_valid,
  input  logic [7:0]                     in_opcode,
  output logic                           in_ready,
  input  logic [7:0]                     pstatus,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [7:0]                     out_opcode,
  output logic [4:0]                     out_initial_state,
  output logic                           out_single_byte,
  output logic                           out_idx_XY,
  output logic                           out_is_branch,
  output logic                           out_take_branch,
  output logic                           out_illegal,
  output logic                           out_read,
  output logic                           out_load,
  output logic                           out_store,
  output logic                           out_rmw,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Sequencer start-state encodings shared with the cycle sequencer
  localparam logic [4:0] T0_FETCH  = 5'd0;
  localparam logic [4:0] T2_ZPG    = 5'd1;
  localparam logic [4:0] T2_ZPGXY  = 5'd2;
  localparam logic [4:0] T2_ABS    = 5'd3;
  localparam logic [4:0] T2_ABSXY  = 5'd4;
  localparam logic [4:0] T2_XIND   = 5'd5;
  localparam logic [4:0] T2_INDY   = 5'd6;
  localparam logic [4:0] T2_JMP    = 5'd7;
  localparam logic [4:0] T2_STACK  = 5'd8;
  localparam logic [4:0] T2_BRANCH = 5'd9;
  localparam logic [4:0] T_JAM     = 5'd31;

  typedef struct packed {
    logic [7:0] opcode;
    logic [4:0] state;
    logic       single_byte;
    logic       idx_xy;
    logic       is_branch;
    logic       illegal;
    logic       rd;
    logic       ld;
    logic       st;
    logic       rmw;
  } entry_t;

  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic [2:0]         w_a;
  logic [2:0]         w_b;
  logic [1:0]         w_c;
  logic               w_mem_none;
  entry_t             w_entry;
  entry_t             w_head;
  logic               w_valid;
  logic               w_push;
  logic               w_pop;
  logic               w_cond;
  logic               w_take;
  logic               w_unused_pstatus;

  assign w_a = in_opcode[7:5];
  assign w_b = in_opcode[4:2];
  assign w_c = in_opcode[1:0];

  // Classification of the offered opcode, stored with it at push time
  always_comb begin
    w_entry             = '0;
    w_entry.opcode      = in_opcode;
    w_entry.state       = T_JAM;
    w_entry.idx_xy      = 1'b1;
    case (w_b)
      3'd0: begin
        if (w_c[0])        w_entry.state = T2_XIND;
        else if (!w_a[2])  w_entry.state = T_JAM;
        else               w_entry.state = T0_FETCH;
      end
      3'd1: w_entry.state = T2_ZPG;
      3'd2: begin
        w_entry.state       = (w_c == 2'd0 && !w_a[2]) ? T2_STACK : T0_FETCH;
        w_entry.single_byte = ~w_c[0];
      end
      3'd3: w_entry.state = (w_a[2:1] == 2'b01 && w_c == 2'd0) ? T2_JMP : T2_ABS;
      3'd4: begin
        if (w_c == 2'd0) begin
          w_entry.is_branch = 1'b1;
        end else begin
          w_entry.state  = T2_INDY;
          w_entry.idx_xy = 1'b0;
        end
      end
      3'd5: begin
        w_entry.state  = T2_ZPGXY;
        w_entry.idx_xy = ~(w_c == 2'd2 && w_a[2:1] == 2'b10);
      end
      3'd6: begin
        if (!w_c[0]) begin
          w_entry.state       = T0_FETCH;
          w_entry.single_byte = 1'b1;
        end else begin
          w_entry.state  = T2_ABSXY;
          w_entry.idx_xy = 1'b0;
        end
      end
      default: begin
        w_entry.state  = T2_ABSXY;
        w_entry.idx_xy = ~(w_c == 2'd2 && w_a[2:1] == 2'b10);
      end
    endcase

    if (w_c == 2'd3) begin
      w_entry.illegal   = 1'b1;
      w_entry.is_branch = 1'b0;
      if (ILLEGAL_NOP) begin
        w_entry.state       = T0_FETCH;
        w_entry.single_byte = 1'b1;
        w_entry.idx_xy      = 1'b1;
      end else begin
        w_entry.state = T_JAM;
      end
    end

    w_mem_none = w_entry.single_byte | w_entry.is_branch | (w_entry.state == T_JAM);
    if (!w_mem_none) begin
      if (w_a == 3'd4 && in_opcode != 8'h80)    w_entry.st  = 1'b1;
      else if (w_a == 3'd5)                     w_entry.ld  = 1'b1;
      else if (w_c == 2'd2 && w_b[0])           w_entry.rmw = 1'b1;
      else                                      w_entry.rd  = 1'b1;
    end
  end

  assign w_valid = (r_count != '0);
  assign w_push  = in_valid & (r_count < CNT_W'(DEPTH));
  assign w_pop   = out_ready & w_valid;

  // Queue pointers and occupancy; flush empties the queue, reset wins over flush
  always_ff @(posedge i_clk) begin
    if (i_rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      if (w_pop)
        r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)
        r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push)
        r_count <= r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !flush && !i_rst)
      r_mem[r_wr_ptr] <= w_entry;
  end

  assign w_head = r_mem[r_rd_ptr];

  // Branch condition against live flags: a[2:1] picks N/V/C/Z, a[0] picks polarity
  always_comb begin
    case (w_head.opcode[7:5])
      3'd0:    w_cond = ~pstatus[7];
      3'd1:    w_cond =  pstatus[7];
      3'd2:    w_cond = ~pstatus[6];
      3'd3:    w_cond =  pstatus[6];
      3'd4:    w_cond = ~pstatus[0];
      3'd5:    w_cond =  pstatus[0];
      3'd6:    w_cond = ~pstatus[1];
      default: w_cond =  pstatus[1];
    endcase
  end

  assign w_unused_pstatus = ^pstatus[5:2];
  assign w_take = w_valid & w_head.is_branch & w_cond;

  assign in_ready          = (r_count < CNT_W'(DEPTH));
  assign out_valid         = w_valid;
  assign count             = r_count;
  assign out_opcode        = w_valid ? w_head.opcode : 8'h00;
  assign out_initial_state = !w_valid          ? 5'd0 :
                             w_head.is_branch  ? (w_take ? T2_BRANCH : T0_FETCH) :
                                                 w_head.state;
  assign out_single_byte   = w_valid & w_head.single_byte;
  assign out_idx_XY        = w_valid & w_head.idx_xy;
  assign out_is_branch     = w_valid & w_head.is_branch;
  assign out_take_branch   = w_take;
  assign out_illegal       = w_valid & w_head.illegal;
  assign out_read          = w_valid & w_head.rd;
  assign out_load          = w_valid & w_head.ld;
  assign out_store         = w_valid & w_head.st;
  assign out_rmw           = w_valid & w_head.rmw;

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Parametrised opcode pre-decode stage with a DEPTH-entry queue between instruction fetch and the cycle sequencer.
- Accepts opcode bytes on a valid/ready handshake and splits each into fields {a[7:5], b[4:2], c[1:0]}.
- Classifies addressing mode, initial sequencer state and memory access pattern, and buffers the results in FIFO order.
- Resolves branch conditions at dequeue time against live pstatus, so flag updates made after enqueue are honoured.

Parameters:
DEPTH, 2, number of queue entries (>=1, any integer, not necessarily a power of two)
ILLEGAL_NOP, 0, c==3 opcodes: 0 -> T_JAM; 1 -> single-byte NOP (T0_FETCH)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
flush  in  1  discard all queued entries
in_valid  in  1  opcode offered
in_opcode  in  8  opcode byte
in_ready  out  1  queue can accept (count<DEPTH)
pstatus  in  8  live status register (N7 V6 D3 I2 Z1 C0)
out_valid  out  1  head entry present
out_ready  in  1  consumer takes head
out_opcode  out  8  head opcode
out_initial_state  out  5  sequencer start state (shared state encodings)
out_single_byte  out  1  no operand byte
out_idx_XY  out  1  index register: 1=X, 0=Y
out_is_branch  out  1  conditional branch
out_take_branch  out  1  branch condition true for current pstatus
out_illegal  out  1  c==3 opcode
out_read, out_load, out_store, out_rmw  out  1 each  memory access class (one-hot or all zero)
count  out  $clog2(DEPTH+1)  occupancy

Behaviour:
- Reset (synchronous, also mid-operation): count=0, pointers=0, out_valid=0, in_ready=1. All out_* fields are 0 whenever out_valid=0.
- Push: in_valid && in_ready. Pop: out_valid && out_ready. Both may occur in the same cycle; count is unchanged.
- Full: in_ready=0 and the offered opcode is not taken, even if a pop occurs that cycle.
- Pointers wrap from DEPTH-1 to 0.
- Latency: an opcode pushed into an empty queue at edge N is at the head with out_valid=1 after edge N. No combinational path from in_* to out_*.
- flush: next cycle count=0. Overrides a push and a pop in the same cycle. i_rst overrides flush.
- Classification is computed at push and stored. Defaults: single_byte=0, idx_XY=1, state=T_JAM.
  - b=0: c odd -> T2_XIND; c even & a<4 -> T_JAM; else T0_FETCH.
  - b=1: T2_ZPG.
  - b=2: (c==0 & a<4) -> T2_STACK, else T0_FETCH; single_byte = !c[0].
  - b=3: (a[2:1]==01 & c==0) -> T2_JMP; else T2_ABS.
  - b=4: c==0 -> is_branch=1; else T2_INDY, idx_XY=0.
  - b=5: T2_ZPGXY; idx_XY = !(c==2 & a[2:1]==10).
  - b=6: c even -> T0_FETCH, single_byte=1; else T2_ABSXY, idx_XY=0.
  - b=7: T2_ABSXY; idx_XY as for b=5.
  - c==3 overrides all of the above: illegal=1. ILLEGAL_NOP=0 -> T_JAM; ILLEGAL_NOP=1 -> T0_FETCH, single_byte=1, idx_XY=1, memory class none.
- Memory class (stored):
  - None if single_byte, is_branch, or state==T_JAM.
  - Otherwise store if a==4 (except opcode 0x80, which is read); else load if a==5; else rmw if c==2 & b odd; else read.
- Branch (combinational from head entry and current pstatus), indexed by a:
  - 0 !N; 1 N; 2 !V; 3 V; 4 !C; 5 C; 6 !Z; 7 Z.
  - out_initial_state = take ? T2_BRANCH : T0_FETCH. out_take_branch=0 for non-branch entries.

Test Plan:
- Assert i_rst 1 cycle with in_valid=1 -> out_valid=0, in_ready=1, count=0, all out_* fields 0; the opcode is not enqueued.
- Push 0xAD into empty queue at edge N -> after N: out_valid=1, out_initial_state=T2_ABS, out_load=1, out_single_byte=0, count=1.
- Hold 0xF0 at head with out_ready=0. pstatus=0x00 -> take_branch=0, state=T0_FETCH. pstatus=0x02 -> take_branch=1, state=T2_BRANCH in the same cycle. No memory class set.
- DEPTH=2: push 0xE8, 0x0A, then offer 0xB1 -> in_ready=0, 0xB1 not taken. Pop twice -> 0xE8 (T0_FETCH, single_byte=1) then 0x0A (single_byte=1, rmw=0). Then push 0xB1 -> T2_INDY, idx_XY=0, load=1. Also check wrap-around and push+pop in one cycle leaving count unchanged.
- Opcode 0x03: ILLEGAL_NOP=0 -> illegal=1, T_JAM, class none. ILLEGAL_NOP=1 -> illegal=1, T0_FETCH, single_byte=1.
- count=2 with flush, push and pop all asserted in one cycle -> next cycle count=0, out_valid=0, pushed byte dropped. The following push behaves as into an empty queue.
